// File: rtl/dec_scan_pkg.sv
// Shared types, mode encodings and decode helper for the dec_scan_n decoder.
package dec_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest supported select; callers slice the result down to their OUT_W.
  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 256;

  // One-hot decode of an index, zero-extended to the widest output.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    return MAX_OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/dec_scan_tick.sv
// Dwell counter: pulses step_c while the count equals the programmed dwell.
module dec_scan_tick #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step_c
);

  logic [DWELL_W-1:0] count;

  // Step is taken on the last cycle of each dwell window.
  assign step_c = (count == dwell);

  // Count up, restarting on clear or at the end of a dwell window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || step_c) begin
      count <= '0;
    end else begin
      count <= count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/dec_scan_n.sv
// Registered one-hot decoder with direct-select and auto-scan modes.
module dec_scan_n
  import dec_scan_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned OUT_W   = 2**SEL_W,
  parameter int unsigned DWELL_W = 16,
  parameter bit          ACT_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [SEL_W-1:0]   last_idx,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y_out,
  output logic [SEL_W-1:0]   idx_out,
  output logic               valid,
  output logic               wrap
);

  localparam logic [OUT_W-1:0] Y_INACTIVE = {OUT_W{ACT_LOW}};

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [OUT_W-1:0] y_nxt;
  logic             valid_nxt;
  logic             wrap_nxt;
  logic             cnt_clr;
  logic             step_c;

  dec_scan_tick #(
    .DWELL_W(DWELL_W)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .dwell (dwell),
    .step_c(step_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: enable gates everything, mode picks DIRECT or SCAN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = (mode == MODE_SCAN) ? SCAN : DIRECT;
      end
      DIRECT, SCAN: begin
        if (!en)                    state_nxt = IDLE;
        else if (mode == MODE_SCAN) state_nxt = SCAN;
        else                        state_nxt = DIRECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next output values; scan entry restarts at index 0 with a fresh dwell.
  always_comb begin
    idx_nxt   = '0;
    valid_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    cnt_clr   = 1'b1;
    y_nxt     = Y_INACTIVE;
    case (state_nxt)
      DIRECT: begin
        idx_nxt   = sel_in;
        valid_nxt = 1'b1;
      end
      SCAN: begin
        valid_nxt = 1'b1;
        if (state == SCAN) begin
          cnt_clr = 1'b0;
          idx_nxt = idx_out;
          if (step_c) begin
            // An index at or above last_idx (last_idx may have been lowered) wraps to 0.
            if (idx_out >= last_idx) begin
              idx_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              idx_nxt = idx_out + SEL_W'(1);
            end
          end
        end
      end
      default: ;
    endcase
    if (valid_nxt) begin
      y_nxt = OUT_W'(onehot(MAX_SEL_W'(idx_nxt))) ^ Y_INACTIVE;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_out   <= Y_INACTIVE;
      idx_out <= '0;
      valid   <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      y_out   <= y_nxt;
      idx_out <= idx_nxt;
      valid   <= valid_nxt;
      wrap    <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_dec_scan_n.sv
// Directed bench for dec_scan_n: 3-bit, 3-bit active-low and 4-bit instances.
module tb_dec_scan_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  sel_in = '0;
  logic [2:0]  last_idx = '0;
  logic [15:0] dwell = '0;
  logic [3:0]  sel4 = '0;
  logic [3:0]  last4 = 4'd15;

  logic [7:0]  y_out, y_al;
  logic [2:0]  idx_out, idx_al;
  logic        valid, valid_al, wrap, wrap_al;
  logic [15:0] y16;
  logic [3:0]  idx16;
  logic        valid16, wrap16;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec_scan_n #(.SEL_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
    .last_idx(last_idx), .dwell(dwell),
    .y_out(y_out), .idx_out(idx_out), .valid(valid), .wrap(wrap)
  );

  dec_scan_n #(.SEL_W(3), .ACT_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
    .last_idx(last_idx), .dwell(dwell),
    .y_out(y_al), .idx_out(idx_al), .valid(valid_al), .wrap(wrap_al)
  );

  dec_scan_n #(.SEL_W(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel4),
    .last_idx(last4), .dwell(dwell),
    .y_out(y16), .idx_out(idx16), .valid(valid16), .wrap(wrap16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic restart_scan(input logic [2:0] li, input logic [15:0] dw);
    en = 1'b0;
    tick();
    last_idx = li;
    dwell = dw;
    en = 1'b1;
    mode = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_cmp++; if (y_out !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", y_out); end
    n_cmp++; if (y_al !== 8'hFF) begin n_fail++; $display("FAIL reset_y_al: got %h expected ff", y_al); end
    n_cmp++; if ({idx_out, valid, wrap} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got idx=%0d v=%b w=%b expected 0/0/0", idx_out, valid, wrap); end
    rst = 1'b0;
    tick();
    restart_scan(3'd7, 16'd0);
    repeat (5) tick();
    n_cmp++; if (idx_out !== 3'd5) begin n_fail++; $display("FAIL pre_reset_idx: got %0d expected 5", idx_out); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (y_out !== 8'h00) begin n_fail++; $display("FAIL async_reset_y: got %h expected 00", y_out); end
    n_cmp++; if (y_al !== 8'hFF) begin n_fail++; $display("FAIL async_reset_y_al: got %h expected ff", y_al); end
    n_cmp++; if ({idx_out, valid, wrap} !== 5'b0) begin n_fail++; $display("FAIL async_reset_flags: got idx=%0d v=%b w=%b expected 0/0/0", idx_out, valid, wrap); end
    en = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got valid=%b expected 0", valid); end
  endtask

  task automatic test_direct();
    logic [7:0] e;
    en = 1'b1; mode = 1'b0; sel_in = 3'b110;
    tick();
    n_cmp++; if (y_out !== 8'h40 || idx_out !== 3'd6 || valid !== 1'b1 || wrap !== 1'b0) begin n_fail++; $display("FAIL direct_6: got y=%h idx=%0d v=%b w=%b expected 40/6/1/0", y_out, idx_out, valid, wrap); end
    n_cmp++; if (y_al !== 8'hBF) begin n_fail++; $display("FAIL direct_6_al: got %h expected bf", y_al); end
    sel_in = 3'b100;
    #2;
    n_cmp++; if (y_out !== 8'h40) begin n_fail++; $display("FAIL direct_latency: got %h expected 40", y_out); end
    tick();
    n_cmp++; if (y_out !== 8'h10 || idx_out !== 3'd4) begin n_fail++; $display("FAIL direct_4: got y=%h idx=%0d expected 10/4", y_out, idx_out); end
    for (int i = 0; i < 200; i++) begin
      sel_in = 3'($urandom_range(0, 7));
      e = 8'd1 << sel_in;
      tick();
      n_cmp++; if (y_out !== e || idx_out !== sel_in) begin n_fail++; $display("FAIL direct_rand: got y=%h idx=%0d expected %h/%0d", y_out, idx_out, e, sel_in); end
    end
  endtask

  task automatic test_scan();
    logic [7:0] e;
    logic [2:0] ei;
    logic       ew;
    last_idx = 3'd7; dwell = 16'd2; mode = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 3; c++) begin
        if (k != 0 || c != 0) tick();
        ei = 3'(k % 8);
        e = 8'd1 << ei;
        ew = (k == 8 && c == 0);
        n_cmp++; if (y_out !== e || idx_out !== ei || wrap !== ew || valid !== 1'b1) begin n_fail++; $display("FAIL scan_k%0d_c%0d: got y=%h idx=%0d w=%b v=%b expected %h/%0d/%b/1", k, c, y_out, idx_out, wrap, valid, e, ei, ew); end
      end
    end
  endtask

  task automatic test_scan_edges();
    restart_scan(3'd0, 16'd0);
    n_cmp++; if (y_out !== 8'h01 || wrap !== 1'b0) begin n_fail++; $display("FAIL scan0_entry: got y=%h w=%b expected 01/0", y_out, wrap); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (y_out !== 8'h01 || idx_out !== 3'd0 || wrap !== 1'b1) begin n_fail++; $display("FAIL scan0_hold%0d: got y=%h idx=%0d w=%b expected 01/0/1", i, y_out, idx_out, wrap); end
    end
    restart_scan(3'd7, 16'd0);
    repeat (5) tick();
    n_cmp++; if (idx_out !== 3'd5) begin n_fail++; $display("FAIL shrink_pre: got idx=%0d expected 5", idx_out); end
    last_idx = 3'd2;
    tick();
    n_cmp++; if (idx_out !== 3'd0 || wrap !== 1'b1 || y_out !== 8'h01) begin n_fail++; $display("FAIL shrink_wrap: got idx=%0d w=%b y=%h expected 0/1/01", idx_out, wrap, y_out); end
    tick();
    n_cmp++; if (idx_out !== 3'd1 || wrap !== 1'b0) begin n_fail++; $display("FAIL shrink_next: got idx=%0d w=%b expected 1/0", idx_out, wrap); end
  endtask

  task automatic test_mode_enable();
    restart_scan(3'd7, 16'd0);
    repeat (4) tick();
    n_cmp++; if (idx_out !== 3'd4) begin n_fail++; $display("FAIL mode_pre: got idx=%0d expected 4", idx_out); end
    mode = 1'b0; sel_in = 3'd2;
    tick();
    n_cmp++; if (y_out !== 8'h04 || idx_out !== 3'd2 || valid !== 1'b1 || wrap !== 1'b0) begin n_fail++; $display("FAIL scan_to_direct: got y=%h idx=%0d v=%b w=%b expected 04/2/1/0", y_out, idx_out, valid, wrap); end
    mode = 1'b1;
    tick();
    n_cmp++; if (y_out !== 8'h01 || idx_out !== 3'd0 || wrap !== 1'b0) begin n_fail++; $display("FAIL direct_to_scan: got y=%h idx=%0d w=%b expected 01/0/0", y_out, idx_out, wrap); end
    tick();
    n_cmp++; if (idx_out !== 3'd1) begin n_fail++; $display("FAIL rescan_step: got idx=%0d expected 1", idx_out); end
    en = 1'b0;
    tick();
    n_cmp++; if (y_out !== 8'h00 || valid !== 1'b0 || idx_out !== 3'd0 || wrap !== 1'b0) begin n_fail++; $display("FAIL disable: got y=%h v=%b idx=%0d w=%b expected 00/0/0/0", y_out, valid, idx_out, wrap); end
    n_cmp++; if (y_al !== 8'hFF) begin n_fail++; $display("FAIL disable_al: got %h expected ff", y_al); end
  endtask

  task automatic test_param();
    logic [15:0] e;
    logic [3:0]  ei;
    logic        ew;
    last4 = 4'd15; dwell = 16'd1;
    en = 1'b1; mode = 1'b1;
    tick();
    for (int k = 0; k < 17; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (k != 0 || c != 0) tick();
        ei = 4'(k % 16);
        e = 16'd1 << ei;
        ew = (k == 16 && c == 0);
        n_cmp++; if (y16 !== e || idx16 !== ei || wrap16 !== ew || valid16 !== 1'b1) begin n_fail++; $display("FAIL wide_k%0d_c%0d: got y=%h idx=%0d w=%b v=%b expected %h/%0d/%b/1", k, c, y16, idx16, wrap16, valid16, e, ei, ew); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan();
    test_scan_edges();
    test_mode_enable();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dec_scan_n.md
# dec_scan_n

Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder with an auto-scan mode, successor to the combinational 3-to-8 decoder. Direct mode decodes a select input with one-cycle latency. Scan mode walks the one-hot output through indices 0..last_idx with a programmable dwell time, for digit-select and LED-scan drivers. It sits between control logic and display or row-select pins.

## Interface
- SEL_W, 3, select/index width
- OUT_W, 2**SEL_W, one-hot output width (derived; do not override)
- DWELL_W, 16, dwell counter width
- ACT_LOW, 0, 1 = output one-cold (inverted) at the pins
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; 0 forces outputs inactive
- mode  in  1  0 = DIRECT, 1 = SCAN
- sel_in  in  SEL_W  index to decode in DIRECT
- last_idx  in  SEL_W  highest index visited in SCAN
- dwell  in  DWELL_W  extra cycles per index in SCAN (dwell+1 cycles per step)
- y_out  out  OUT_W  registered one-hot output (one-cold if ACT_LOW)
- idx_out  out  SEL_W  index currently driven on y_out
- valid  out  1  y_out carries a decoded index
- wrap  out  1  one-cycle pulse when scan steps from last_idx to 0

## Operation
- States: IDLE, DIRECT, SCAN.
- IDLE when en=0. From IDLE with en=1, go to DIRECT if mode=0, otherwise SCAN.
- In DIRECT or SCAN, en=0 returns to IDLE on the next edge.
- A mode change while enabled switches between DIRECT and SCAN on the next edge.
- IDLE:
  - y_out inactive: all 0, or all 1 when ACT_LOW.
  - valid=0, idx_out=0, dwell counter cleared.
- DIRECT:
  - idx_out <= sel_in; y_out <= 1<<sel_in (inverted if ACT_LOW); valid=1.
- SCAN entry: idx_out=0, counter=0, valid=1.
- SCAN stepping:
  - Counter increments each cycle.
  - When counter==dwell, the counter clears and the index advances.
  - Advance rule: idx==last_idx -> 0 with wrap=1; otherwise idx+1.
  - If idx>last_idx (last_idx lowered mid-scan), the next advance goes to 0 and asserts wrap.
- last_idx=0 in SCAN: the output holds index 0, and wrap pulses every dwell+1 cycles.
- dwell=0: advance every cycle. dwell and last_idx are sampled live, not latched.
- wrap is 0 outside SCAN.
- All index arithmetic is unsigned SEL_W wide. The counter compare is unsigned DWELL_W wide.

## Timing
- Reset values: y_out inactive (0, or all-ones if ACT_LOW); idx_out=0; valid=0; wrap=0; state IDLE; counter=0.
- Reset asserted mid-scan clears everything immediately (async). The first edge after deassertion evaluates en and mode.
- DIRECT latency: 1 cycle from sel_in to y_out/idx_out.
- en rise to valid=1: 1 cycle. en fall to valid=0: 1 cycle.
- SCAN: each index is held exactly dwell+1 cycles. The first index (0) is held dwell+1 cycles counted from the entry edge.
- wrap is high in the same cycle y_out first shows index 0 after the wrap.
- DIRECT->SCAN restarts at index 0. SCAN->DIRECT shows sel_in after 1 cycle.
- y_out, idx_out, valid and wrap are all registered. No combinational path from inputs to outputs.

## Structure
- Package dec_scan_pkg holds:
  - the state typedef (IDLE, DIRECT, SCAN)
  - the mode constants MODE_DIRECT=0 and MODE_SCAN=1
  - the onehot(SEL_W) function
- Sub-module dec_scan_tick: a DWELL_W counter with clear, producing a step pulse when count==dwell. It is instantiated once.
- The top module holds the FSM, index register, decode and ACT_LOW inversion.

## Test plan
- Reset: assert rst mid-SCAN at idx 5 -> y_out=8'h00, idx_out=0, valid=0, wrap=0 immediately. With ACT_LOW=1 -> y_out=8'hFF.
- DIRECT: en=1, mode=0, sel_in=3'b110 then 3'b100 -> y_out=8'h40 then 8'h10, each one cycle after the input change. Random sel_in for 200 cycles, checked against 1<<sel_in.
- SCAN: last_idx=7, dwell=2 -> idx 0,1,…,7,0 with each held 3 cycles. wrap high only on the 7->0 step, with y_out=8'h01 in that cycle.
- SCAN edges: dwell=0, last_idx=0 -> y_out constant 8'h01 with wrap every cycle. last_idx changed from 7 to 2 while idx=5 -> next step goes to 0 with wrap=1.
- Mode/enable: SCAN at idx 4, switch mode=0 with sel_in=2 -> y_out=8'h04 next cycle. Switch back -> restarts at 0. en=0 -> valid=0 and y_out=0 next cycle.
- Parametrisation: SEL_W=4, last_idx=15, dwell=1 -> 16 one-hot states on a 16-bit y_out, each held 2 cycles, with one wrap per 32 cycles.
